// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage: load/store encodings and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LB      = 3'b001,
    LH      = 3'b010,
    LW      = 3'b011,
    LBU     = 3'b100,
    LHU     = 3'b101
  } load_type_e;

  // 2'b11 is decoded as a word store.
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD2 = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } state_e;

  // Encodings 110/111 are not loads.
  function automatic logic is_load(input logic [2:0] t);
    return (t >= 3'b001) && (t <= 3'b101);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load aligner: picks the addressed byte/half out of a read word and extends it.
// Latency: combinational. Backpressure: none.
// Ports: rdata (read word), addr_lo (byte offset), ld_type (load encoding), ld_data (result).
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    ld_data = rdata;
    case (load_type_e'(ld_type))
      LB:      ld_data = {{24{byte_sel[7]}}, byte_sel};
      LH:      ld_data = {{16{half_sel[15]}}, half_sel};
      LBU:     ld_data = {24'h0, byte_sel};
      LHU:     ld_data = {16'h0, half_sel};
      default: ld_data = rdata; // LW, and don't-care for non-loads
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory port, aligns loads, registers MEM/WB; watchdog on waits.
// Latency: 1 cycle to WB when dm_ready is high in the access cycle; +1 per wait cycle.
// Backpressure: mem_stall = pending & ~dm_ready holds upstream; stalled cycles push a WB bubble.
// Ports: EX/MEM inputs (*_mem), data-memory port (dm_*), mem_stall, fw_from_mem,
// MEM/WB outputs (*_wb), sticky bus_err; misalign_err exists only with MEM_MISALIGN_CHK_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] store_data_mem,
  input  logic [1:0]  store_size_mem,
  input  logic [2:0]  is_load_mem,
  input  logic        is_store_mem,
  input  logic [4:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        mem_stall,
  output logic [31:0] fw_from_mem,
  output logic [4:0]  rd_addr_wb,
  output logic        wb_en_wb,
  output logic [31:0] wb_data_wb,
  output logic        bus_err
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state;
  logic [7:0]  wait_cnt;
  logic        ld, mem_op, mis, pending, wb_kill;
  logic [3:0]  we_lanes;
  logic [31:0] wdata_lanes, ld_data, wb_data_next;

  assign ld     = is_load(is_load_mem);
  assign mem_op = ld | is_store_mem;

`ifdef MEM_MISALIGN_CHK_EN
  logic half_acc, word_acc;
  always_comb begin
    half_acc = 1'b0;
    word_acc = 1'b0;
    if (ld) begin
      half_acc = (is_load_mem == LH) || (is_load_mem == LHU);
      word_acc = (is_load_mem == LW);
    end else if (is_store_mem) begin
      half_acc = (store_size_mem == SZ_HALF);
      word_acc = store_size_mem[1];
    end
    mis = mem_op & ((half_acc & alu_out_mem[0]) | (word_acc & (|alu_out_mem[1:0])));
  end

  always_ff @(posedge clk) begin
    if (!rst) misalign_err <= 1'b0;
    else if (mis) misalign_err <= 1'b1;
  end
`else
  assign mis = 1'b0;
`endif

  // A misaligned access never reaches memory, so it never waits.
  assign pending   = mem_op & (state != ERR) & ~mis;
  assign mem_stall = pending & ~dm_ready;
  assign wb_kill   = mem_op & ((state == ERR) | mis);

  always_comb begin
    we_lanes    = 4'b1111;
    wdata_lanes = store_data_mem;
    case (store_size_mem)
      2'b00: begin
        we_lanes    = 4'b0001 << alu_out_mem[1:0];
        wdata_lanes = {4{store_data_mem[7:0]}};
      end
      2'b01: begin
        we_lanes    = 4'b0011 << {alu_out_mem[1], 1'b0};
        wdata_lanes = {2{store_data_mem[15:0]}};
      end
      default: ;
    endcase
  end

  assign dm_req      = pending;
  // A load flag wins over a simultaneous store flag.
  assign dm_we       = (pending && is_store_mem && !ld) ? we_lanes : 4'b0000;
  assign dm_wdata    = wdata_lanes;
  assign dm_addr     = {alu_out_mem[31:2], 2'b00};
  assign fw_from_mem = alu_out_mem;

  mem_load_align u_align (
    .rdata   (dm_rdata),
    .addr_lo (alu_out_mem[1:0]),
    .ld_type (is_load_mem),
    .ld_data (ld_data)
  );

  assign wb_data_next = ld ? ld_data : alu_out_mem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      bus_err    <= 1'b0;
      rd_addr_wb <= 5'd0;
      wb_en_wb   <= 1'b0;
      wb_data_wb <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pending && !dm_ready) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          // Leaving on !pending keeps the FSM sane if upstream ever drops the request.
          if (dm_ready || !pending) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TO_LIM) begin
            state   <= ERR;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ERR; // ERR holds until reset
      endcase

      if (mem_stall) begin
        wb_en_wb <= 1'b0; // bubble; rd/data hold
      end else begin
        rd_addr_wb <= rd_addr_mem;
        wb_en_wb   <= wb_en_mem & ~wb_kill;
        wb_data_wb <= wb_data_next;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, load lanes, store lanes,
// waited store, load/store conflict, mid-access reset and watchdog timeout.
// Optional misaligned-access checks when MEM_MISALIGN_CHK_EN is defined.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_mem, store_data_mem, dm_rdata;
  logic [1:0]  store_size_mem;
  logic [2:0]  is_load_mem;
  logic        is_store_mem, wb_en_mem, dm_ready;
  logic [4:0]  rd_addr_mem;
  logic        dm_req, mem_stall, wb_en_wb, bus_err;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, fw_from_mem, wb_data_wb;
  logic [4:0]  rd_addr_wb;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .alu_out_mem(alu_out_mem), .store_data_mem(store_data_mem),
    .store_size_mem(store_size_mem), .is_load_mem(is_load_mem),
    .is_store_mem(is_store_mem), .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mem_stall(mem_stall),
    .fw_from_mem(fw_from_mem), .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb),
    .wb_data_wb(wb_data_wb), .bus_err(bus_err)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sz,
                       input logic [2:0] lt, input logic st, input logic [4:0] rd,
                       input logic we);
    alu_out_mem    = a;
    store_data_mem = sd;
    store_size_mem = sz;
    is_load_mem    = lt;
    is_store_mem   = st;
    rd_addr_mem    = rd;
    wb_en_mem      = we;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    drive(32'h0, 32'h0, 2'b00, 3'b000, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    checks++; if (wb_en_wb !== 1'b0) begin fails++; $display("FAIL reset_wb_en: got %b want 0", wb_en_wb); end
    checks++; if (rd_addr_wb !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", rd_addr_wb); end
    checks++; if (wb_data_wb !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", wb_data_wb); end
    checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    checks++; if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL reset_req_stall: got %b%b want 00", dm_req, mem_stall); end
`ifdef MEM_MISALIGN_CHK_EN
    checks++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_pass_through();
    drive(32'h55, 32'h0, 2'b00, 3'b000, 1'b0, 5'd7, 1'b1);
    #1;
    checks++; if (dm_req !== 1'b0) begin fails++; $display("FAIL pt_req: got %b want 0", dm_req); end
    checks++; if (fw_from_mem !== 32'h55) begin fails++; $display("FAIL pt_fw: got %h want 55", fw_from_mem); end
    tick();
    checks++; if (wb_data_wb !== 32'h55 || rd_addr_wb !== 5'd7 || wb_en_wb !== 1'b1) begin
      fails++; $display("FAIL pt_wb: got data=%h rd=%0d en=%b want 55/7/1", wb_data_wb, rd_addr_wb, wb_en_wb); end
  endtask

  task automatic test_load_lanes();
    logic [31:0] addr [7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1001, 32'h1000};
    logic [2:0]  lt   [7] = '{LB, LBU, LB, LH, LHU, LBU, LW};
    logic [31:0] exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'hFFFF_80FF,
                              32'h0000_1234, 32'h0000_0012, 32'h80FF_1234};
    dm_rdata = 32'h80FF_1234;
    dm_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(addr[i], 32'h0, 2'b00, lt[i], 1'b0, 5'd3, 1'b1);
      #1;
      checks++; if (dm_req !== 1'b1 || mem_stall !== 1'b0 || dm_we !== 4'b0000 || dm_addr !== 32'h1000) begin
        fails++; $display("FAIL load%0d_port: got req=%b stall=%b we=%b addr=%h want 1/0/0000/1000",
                          i, dm_req, mem_stall, dm_we, dm_addr); end
      tick();
      checks++; if (wb_data_wb !== exp[i] || wb_en_wb !== 1'b1 || rd_addr_wb !== 5'd3) begin
        fails++; $display("FAIL load%0d_wb: got data=%h en=%b rd=%0d want %h/1/3",
                          i, wb_data_wb, wb_en_wb, rd_addr_wb, exp[i]); end
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] addr [5] = '{32'h2001, 32'h2003, 32'h2000, 32'h2000, 32'h2004};
    logic [31:0] sd   [5] = '{32'h1234_565A, 32'h0000_00C3, 32'h0000_7788, 32'hDEAD_BEEF, 32'h0102_0304};
    logic [1:0]  sz   [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0]  ewe  [5] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1111};
    logic [31:0] ewd  [5] = '{32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h7788_7788, 32'hDEAD_BEEF, 32'h0102_0304};
    dm_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(addr[i], sd[i], sz[i], 3'b000, 1'b1, 5'd2, 1'b0);
      #1;
      checks++; if (dm_we !== ewe[i] || dm_wdata !== ewd[i] || dm_req !== 1'b1 || mem_stall !== 1'b0) begin
        fails++; $display("FAIL store%0d: got we=%b wdata=%h req=%b stall=%b want %b/%h/1/0",
                          i, dm_we, dm_wdata, dm_req, mem_stall, ewe[i], ewd[i]); end
      tick();
    end
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    dm_ready = 1'b0;
    drive(32'h2002, 32'h0000_ABCD, 2'b01, 3'b000, 1'b1, 5'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_stall === 1'b1) stalls++;
      checks++; if (dm_we !== 4'b1100 || dm_wdata !== 32'hABCD_ABCD) begin
        fails++; $display("FAIL sh_lanes: got we=%b wdata=%h want 1100/abcdabcd", dm_we, dm_wdata); end
      tick();
      checks++; if (wb_en_wb !== 1'b0 || wb_data_wb !== 32'h2004 || rd_addr_wb !== 5'd2) begin
        fails++; $display("FAIL sh_bubble: got en=%b data=%h rd=%0d want 0/2004/2", wb_en_wb, wb_data_wb, rd_addr_wb); end
    end
    dm_ready = 1'b1;
    #1;
    if (mem_stall === 1'b1) stalls++;
    checks++; if (stalls !== 3) begin fails++; $display("FAIL sh_stall_cycles: got %0d want 3", stalls); end
    tick();
    checks++; if (wb_en_wb !== 1'b0 || wb_data_wb !== 32'h2002 || rd_addr_wb !== 5'd12) begin
      fails++; $display("FAIL sh_retire: got en=%b data=%h rd=%0d want 0/2002/12", wb_en_wb, wb_data_wb, rd_addr_wb); end
  endtask

  task automatic test_load_store_both();
    dm_ready = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    drive(32'h1000, 32'h1111_1111, 2'b10, LW, 1'b1, 5'd5, 1'b1);
    #1;
    checks++; if (dm_we !== 4'b0000 || dm_req !== 1'b1) begin
      fails++; $display("FAIL ldst_port: got we=%b req=%b want 0000/1", dm_we, dm_req); end
    tick();
    checks++; if (wb_data_wb !== 32'hCAFE_F00D || wb_en_wb !== 1'b1) begin
      fails++; $display("FAIL ldst_wb: got data=%h en=%b want cafef00d/1", wb_data_wb, wb_en_wb); end
  endtask

  task automatic test_reset_mid_access();
    dm_ready = 1'b0;
    drive(32'h1000, 32'h0, 2'b00, LW, 1'b0, 5'd9, 1'b1);
    tick();
    tick();
    checks++; if (mem_stall !== 1'b1) begin fails++; $display("FAIL rstmid_waiting: got stall=%b want 1", mem_stall); end
    rst = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 3'b000, 1'b0, 5'd0, 1'b0);
    tick();
    checks++; if (dm_req !== 1'b0 || wb_en_wb !== 1'b0 || rd_addr_wb !== 5'd0 || wb_data_wb !== 32'h0) begin
      fails++; $display("FAIL rstmid_clear: got req=%b en=%b rd=%0d data=%h want 0/0/0/0",
                        dm_req, wb_en_wb, rd_addr_wb, wb_data_wb); end
    rst = 1'b1;
    dm_ready = 1'b1;
    dm_rdata = 32'h1122_3344;
    drive(32'h1000, 32'h0, 2'b00, LW, 1'b0, 5'd4, 1'b1);
    #1;
    checks++; if (mem_stall !== 1'b0 || dm_req !== 1'b1) begin
      fails++; $display("FAIL rstmid_fresh: got stall=%b req=%b want 0/1", mem_stall, dm_req); end
    tick();
    checks++; if (wb_data_wb !== 32'h1122_3344 || rd_addr_wb !== 5'd4) begin
      fails++; $display("FAIL rstmid_wb: got data=%h rd=%0d want 11223344/4", wb_data_wb, rd_addr_wb); end
  endtask

  task automatic test_timeout();
    dm_ready = 1'b0;
    drive(32'h1000, 32'h0, 2'b00, LW, 1'b0, 5'd6, 1'b1);
    // One IDLE cycle plus four WAIT cycles (wait_cnt 1..4) before the watchdog fires.
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_stall !== 1'b1 || bus_err !== 1'b0) begin
        fails++; $display("FAIL to_wait%0d: got stall=%b err=%b want 1/0", i, mem_stall, bus_err); end
      tick();
    end
    checks++; if (bus_err !== 1'b1 || mem_stall !== 1'b0 || dm_req !== 1'b0 || wb_en_wb !== 1'b0) begin
      fails++; $display("FAIL to_fire: got err=%b stall=%b req=%b en=%b want 1/0/0/0",
                        bus_err, mem_stall, dm_req, wb_en_wb); end
    tick();
    checks++; if (wb_en_wb !== 1'b0 || bus_err !== 1'b1) begin
      fails++; $display("FAIL to_retire: got en=%b err=%b want 0/1", wb_en_wb, bus_err); end
    drive(32'h77, 32'h0, 2'b00, 3'b000, 1'b0, 5'd8, 1'b1);
    tick();
    checks++; if (wb_data_wb !== 32'h77 || wb_en_wb !== 1'b1 || rd_addr_wb !== 5'd8) begin
      fails++; $display("FAIL to_passthru: got data=%h en=%b rd=%0d want 77/1/8", wb_data_wb, wb_en_wb, rd_addr_wb); end
    drive(32'h1000, 32'h0, 2'b00, LB, 1'b0, 5'd1, 1'b1);
    dm_ready = 1'b1;
    #1;
    checks++; if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      fails++; $display("FAIL to_later_load: got req=%b stall=%b want 0/0", dm_req, mem_stall); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL to_clear: got err=%b want 0", bus_err); end
  endtask

`ifdef MEM_MISALIGN_CHK_EN
  task automatic test_misalign();
    dm_ready = 1'b1;
    drive(32'h3001, 32'h0, 2'b00, LW, 1'b0, 5'd10, 1'b1);
    #1;
    checks++; if (dm_req !== 1'b0 || mem_stall !== 1'b0 || dm_we !== 4'b0000) begin
      fails++; $display("FAIL mis_port: got req=%b stall=%b we=%b want 0/0/0000", dm_req, mem_stall, dm_we); end
    tick();
    checks++; if (misalign_err !== 1'b1 || wb_en_wb !== 1'b0) begin
      fails++; $display("FAIL mis_flag: got err=%b en=%b want 1/0", misalign_err, wb_en_wb); end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_load_lanes();
    test_store_lanes();
    test_store_wait();
    test_load_store_both();
    test_reset_mid_access();
    test_timeout();
`ifdef MEM_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
